// File: rtl/turbo_io_pkg.sv
// Shared definitions for the turbo nibble IO path: state encodings,
// nibble width and the default word size in nibbles.
package turbo_io_pkg;

    localparam int NIB_W           = 4;
    localparam int NIBBLES_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

endpackage

// File: rtl/turbo_nib_parity.sv
// Even-parity check for one nibble plus its parity bit.
// The error output is high when the five bits carry odd parity.
module turbo_nib_parity
    import turbo_io_pkg::*;
(
    input  logic [NIB_W-1:0] data_i,
    input  logic             par_i,
    output logic             err_o
);

    assign err_o = ^{data_i, par_i};

endmodule

// File: rtl/turbo_nibble_deser.sv
// Nibble-to-word deserializer for the turbo IO path.
// Nibbles are packed little-end first (nibble k at bits [4k+3:4k]) into a
// working buffer; the completed word is copied to a separate output register,
// so WORD only changes at word completion.
// Optional build macro: TURBO_NIBBLE_PARITY_EN adds a sticky parity-error flag.
module turbo_nibble_deser
    import turbo_io_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEFAULT,
    parameter int WIDTH   = NIB_W * NIBBLES
)(
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [NIB_W-1:0] I,
    input  logic             NIB_VALID,
    input  logic             NIB_SOF,
    input  logic             NIB_PAR,
    output logic             NIB_READY,
    output logic [WIDTH-1:0] WORD,
    output logic             WORD_VALID,
    input  logic             WORD_READY,
    output logic             ABORT,
    output logic             PAR_ERR
);

    localparam int               CNT_W = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] buf_q,   buf_d;
    logic [WIDTH-1:0] word_q,  word_d;
    logic             abort_q, abort_d;
    logic             nib_fire;
    logic [WIDTH-1:0] first_nib;

    // In HOLD a nibble is only taken when the held word drains the same cycle.
    assign NIB_READY  = (state_q != ST_HOLD) || WORD_READY;
    assign nib_fire   = NIB_VALID && NIB_READY;
    assign first_nib  = {{(WIDTH-NIB_W){1'b0}}, I};
    assign WORD       = word_q;
    assign WORD_VALID = (state_q == ST_HOLD);
    assign ABORT      = abort_q;

    // Next-state, nibble placement and word completion.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        state_d = state_q;
        count_d = count_q;
        buf_d   = buf_q;
        word_d  = word_q;
        abort_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (nib_fire) begin
                    buf_d   = first_nib;
                    count_d = CNT_W'(1);
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (nib_fire) begin
                    if (NIB_SOF) begin
                        // Restart framing: drop the partial word and flag it.
                        buf_d   = first_nib;
                        count_d = CNT_W'(1);
                        abort_d = 1'b1;
                    end else if (count_q == LAST) begin
                        word_d                           = buf_q;
                        word_d[count_q*NIB_W +: NIB_W]   = I;
                        buf_d                            = '0;
                        count_d                          = '0;
                        state_d                          = ST_HOLD;
                    end else begin
                        buf_d[count_q*NIB_W +: NIB_W] = I;
                        count_d                       = count_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (WORD_READY) begin
                    if (nib_fire) begin
                        buf_d   = first_nib;
                        count_d = CNT_W'(1);
                        state_d = ST_COLLECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // State, counter, buffers and abort pulse register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            // NOTE: the data registers are reset as well, so WORD reads 0 after reset and no stale nibbles survive.
            buf_q   <= '0;
            word_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            word_q  <= word_d;
            abort_q <= abort_d;
        end
    end

`ifdef TURBO_NIBBLE_PARITY_EN
    logic nib_err;
    logic par_err_q;

    turbo_nib_parity u_parity (
        .data_i (I),
        .par_i  (NIB_PAR),
        .err_o  (nib_err)
    );

    // Sticky parity error on any accepted nibble; cleared only by reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            par_err_q <= 1'b0;
        end else if (nib_fire && nib_err) begin
            par_err_q <= 1'b1;
        end
    end

    assign PAR_ERR = par_err_q;
`else
    logic unused_par;

    assign unused_par = NIB_PAR;
    assign PAR_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_turbo_nibble_deser.sv
// Directed scoreboard bench for turbo_nibble_deser: an 8-nibble instance for
// framing, back-pressure, abort, reset and parity, plus a 2-nibble instance
// for continuous streaming.
module tb_turbo_nibble_deser;

    logic        CLK = 1'b0;
    logic        RESET_N;

    logic [3:0]  a_i;
    logic        a_nv, a_sof, a_par, a_wr;
    logic        a_nr, a_wv, a_abort, a_perr;
    logic [31:0] a_word;

    logic [3:0]  b_i;
    logic        b_nv, b_sof, b_par, b_wr;
    logic        b_nr, b_wv, b_abort, b_perr;
    logic [7:0]  b_word;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] a_q[$];
    logic [7:0]  b_q[$];
    int          a_aborts;
    int          b_drains;
    logic        a_wv_seen, a_nr_seen, a_perr_seen;
    logic [31:0] a_word_seen;
    logic        exp_perr;

    always #5 CLK = ~CLK;

    turbo_nibble_deser #(.NIBBLES(8)) dut_a (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .I          (a_i),
        .NIB_VALID  (a_nv),
        .NIB_SOF    (a_sof),
        .NIB_PAR    (a_par),
        .NIB_READY  (a_nr),
        .WORD       (a_word),
        .WORD_VALID (a_wv),
        .WORD_READY (a_wr),
        .ABORT      (a_abort),
        .PAR_ERR    (a_perr)
    );

    turbo_nibble_deser #(.NIBBLES(2)) dut_b (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .I          (b_i),
        .NIB_VALID  (b_nv),
        .NIB_SOF    (b_sof),
        .NIB_PAR    (b_par),
        .NIB_READY  (b_nr),
        .WORD       (b_word),
        .WORD_VALID (b_wv),
        .WORD_READY (b_wr),
        .ABORT      (b_abort),
        .PAR_ERR    (b_perr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle on instance A: drive after the falling edge, sample 1ns later,
    // score any word drained on the coming rising edge.
    task automatic a_cycle(input logic v, input logic sof, input logic [3:0] nib,
                           input logic par, input logic wr);
        @(negedge CLK);
        a_nv  = v;
        a_sof = sof;
        a_i   = nib;
        a_par = par;
        a_wr  = wr;
        #1;
        a_wv_seen   = a_wv;
        a_nr_seen   = a_nr;
        a_perr_seen = a_perr;
        a_word_seen = a_word;
        if (a_abort) a_aborts++;
        if (a_wv && a_wr) begin
            check("a_sb_entry", 32'(a_q.size() != 0), 32'd1);
            if (a_q.size() != 0) check("a_word", a_word, a_q.pop_front());
        end
        @(posedge CLK);
    endtask

    task automatic a_send(input logic [3:0] nib, input logic sof, input logic wr);
        a_cycle(1'b1, sof, nib, ^nib, wr);
    endtask

    task automatic b_cycle(input logic v, input logic [3:0] nib, input logic exp_wv);
        @(negedge CLK);
        b_nv = v;
        b_i  = nib;
        #1;
        check("b_ready", b_nr, 32'd1);
        check("b_valid", b_wv, exp_wv);
        if (b_wv && b_wr) begin
            b_drains++;
            check("b_sb_entry", 32'(b_q.size() != 0), 32'd1);
            if (b_q.size() != 0) check("b_word", b_word, b_q.pop_front());
        end
        @(posedge CLK);
    endtask

    initial begin
`ifdef TURBO_NIBBLE_PARITY_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        RESET_N = 1'b0;
        a_i = '0; a_nv = 1'b0; a_sof = 1'b0; a_par = 1'b0; a_wr = 1'b0;
        b_i = '0; b_nv = 1'b0; b_sof = 1'b0; b_par = 1'b0; b_wr = 1'b0;
        a_aborts = 0;
        b_drains = 0;

        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        check("rst_word_valid", a_wv, 32'd0);
        check("rst_word", a_word, 32'd0);
        check("rst_abort", a_abort, 32'd0);
        check("rst_par_err", a_perr, 32'd0);
        RESET_N = 1'b1;
        #1;
        check("rst_nib_ready", a_nr, 32'd1);

        // Nibbles 1..8 back-to-back, WORD_VALID one cycle after the last
        a_q.push_back(32'h8765_4321);
        for (int k = 1; k <= 8; k++) begin
            a_send(4'(k), k == 1, 1'b1);
            check("t1_ready", a_nr_seen, 32'd1);
            check("t1_not_valid", a_wv_seen, 32'd0);
        end
        a_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("t1_latency", a_wv_seen, 32'd1);
        a_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("t1_idle_after_drain", a_wv_seen, 32'd0);
        check("t1_no_abort", 32'(a_aborts), 32'd0);

        // Back-pressure: word held for 5 cycles, then drains with nibble A (SOF) passing through
        a_q.push_back(32'h0FED_CBA9);
        for (int k = 0; k < 8; k++) a_send(4'(9 + k), 1'b0, 1'b0);
        for (int s = 0; s < 5; s++) begin
            a_send(4'hA, 1'b1, 1'b0);
            check("t2_stall_ready", a_nr_seen, 32'd0);
            check("t2_stall_valid", a_wv_seen, 32'd1);
            check("t2_stall_word", a_word_seen, 32'h0FED_CBA9);
        end
        a_q.push_back(32'h7654_321A);
        a_send(4'hA, 1'b1, 1'b1);
        check("t2_drain_ready", a_nr_seen, 32'd1);
        for (int k = 1; k <= 7; k++) a_send(4'(k), 1'b0, 1'b1);
        a_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("t2_no_abort", 32'(a_aborts), 32'd0);

        // Mid-word SOF discards the partial word and pulses ABORT once
        a_aborts = 0;
        for (int k = 0; k < 3; k++) a_send(4'h5, 1'b0, 1'b1);
        a_q.push_back(32'hA987_6543);
        a_send(4'h3, 1'b1, 1'b1);
        for (int k = 4; k <= 10; k++) a_send(4'(k), 1'b0, 1'b1);
        a_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("t3_abort_once", 32'(a_aborts), 32'd1);

        // Reset after 5 nibbles: outputs clear at once, next word is clean
        for (int k = 1; k <= 5; k++) a_send(4'(k), 1'b0, 1'b1);
        @(negedge CLK);
        RESET_N = 1'b0;
        a_nv    = 1'b0;
        #1;
        check("t4_rst_valid", a_wv, 32'd0);
        check("t4_rst_word", a_word, 32'd0);
        check("t4_rst_abort", a_abort, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        check("t4_ready", a_nr, 32'd1);
        a_aborts = 0;
        a_q.push_back(32'hFEDC_BA98);
        for (int k = 8; k <= 15; k++) a_send(4'(k), 1'b0, 1'b1);
        a_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("t4_no_abort", 32'(a_aborts), 32'd0);

        // Parity: nibble 1 sent with NIB_PAR=0 (odd overall)
        check("t5_par_clean", a_perr, 32'd0);
        a_q.push_back(32'h8765_4321);
        a_cycle(1'b1, 1'b0, 4'b0001, 1'b0, 1'b1);
        for (int k = 2; k <= 8; k++) begin
            a_send(4'(k), 1'b0, 1'b1);
            check("t5_par_err", a_perr_seen, 32'(exp_perr));
        end
        a_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        a_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("t5_par_sticky", a_perr_seen, 32'(exp_perr));
        check("a_sb_empty", 32'(a_q.size()), 32'd0);

        // NIBBLES=2 continuous stream F,0 with WORD_READY=1
        b_wr = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 1) b_q.push_back(8'h0F);
            b_cycle(1'b1, (k % 2 == 0) ? 4'hF : 4'h0, (k >= 2) && (k % 2 == 0));
        end
        b_cycle(1'b0, 4'h0, 1'b1);
        check("b_drain_count", 32'(b_drains), 32'd10);
        check("b_sb_empty", 32'(b_q.size()), 32'd0);
        check("b_no_abort", b_abort, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/turbo_nibble_deser.md
TURBO_NIBBLE_DESER -- requirements
Module: turbo_nibble_deser

Interface
REQ-001 SHALL have parameter NIBBLES, default 8, meaning nibbles per assembled word (legal 2..16).
REQ-002 SHALL have parameter WIDTH, default 4*NIBBLES, meaning output word width; fixed as derived, not overridden.
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 I  input  4  incoming nibble from the 4-bit IO buffer stage.
REQ-006 NIB_VALID  input  1  I holds a valid nibble this cycle.
REQ-007 NIB_SOF  input  1  qualified by NIB_VALID; this nibble is nibble 0 of a new word.
REQ-008 NIB_PAR  input  1  even-parity bit accompanying I.
REQ-009 NIB_READY  output  1  block accepts a nibble this cycle.
REQ-010 WORD  output  WIDTH  assembled word; nibble k occupies bits [4k+3:4k].
REQ-011 WORD_VALID  output  1  WORD is valid.
REQ-012 WORD_READY  input  1  downstream accepts WORD this cycle.
REQ-013 ABORT  output  1  one-cycle pulse when a partial word is discarded.
REQ-014 PAR_ERR  output  1  sticky parity-error flag.

Function
REQ-015 Nibble transfer SHALL occur when NIB_VALID and NIB_READY are both high; word transfer when WORD_VALID and WORD_READY are both high.
REQ-016 States SHALL be IDLE (count=0, no word held), COLLECT (0<count<NIBBLES), HOLD (word complete, WORD_VALID=1).
REQ-017 IDLE->COLLECT on accepted nibble; nibble stored at index 0, count=1.
REQ-018 COLLECT: each accepted nibble stored at index count, count increments; on the NIBBLES-th nibble SHALL go to HOLD with WORD_VALID=1 the next cycle (latency 1 cycle after last nibble).
REQ-019 HOLD: NIB_READY=1 only if WORD_READY=1 (pass-through on drain); a nibble accepted in the draining cycle SHALL start a new word at index 0 (HOLD->COLLECT); else HOLD->IDLE on drain.
REQ-020 HOLD with WORD_READY=0: NIB_READY=0, WORD and WORD_VALID SHALL remain stable.
REQ-021 NIB_SOF on accepted nibble in COLLECT SHALL discard the partial word, store nibble at index 0, set count=1, and pulse ABORT for one cycle.
REQ-022 NIB_SOF in IDLE or on the first nibble after HOLD drain SHALL be normal (no ABORT).
REQ-023 Nibbles without NIB_SOF are accepted as continuation; an unframed stream SHALL assemble purely by count.
REQ-024 Unfilled nibble slots SHALL never appear with WORD_VALID=1; WORD SHALL be updated only at completion (shadow register), holding the previous word otherwise.
REQ-025 NIB_READY SHALL be 1 in IDLE and COLLECT.

Reset
REQ-026 RESET_N low SHALL asynchronously force state=IDLE, count=0, WORD=0, WORD_VALID=0, ABORT=0, PAR_ERR=0; NIB_READY=1 after release.
REQ-027 Reset mid-word or in HOLD SHALL discard all content without ABORT pulse.

Configuration
REQ-028 Macro TURBO_NIBBLE_PARITY_EN defined: each accepted nibble SHALL be checked (^{I,NIB_PAR} must be 0); mismatch SHALL set PAR_ERR, which stays set until reset; word assembly unaffected.
REQ-029 Macro undefined: NIB_PAR ignored, PAR_ERR tied 0, no parity logic.

Structure
REQ-030 Shared package/header turbo_io_pkg SHALL hold state encodings (IDLE=2'd0, COLLECT=2'd1, HOLD=2'd2), nibble width 4, default NIBBLES.
REQ-031 One sub-module, turbo_nib_parity (4-bit data + parity -> error), SHALL be instantiated only under TURBO_NIBBLE_PARITY_EN.

Verification
REQ-032 Send nibbles 1..8 back-to-back, WORD_READY=1 -> WORD=32'h87654321, WORD_VALID one cycle after 8th nibble.
REQ-033 Complete word with WORD_READY=0 for 5 cycles -> NIB_READY=0, WORD stable; raise WORD_READY with nibble A valid -> word drains, A stored at index 0.
REQ-034 Send 3 nibbles then nibble with NIB_SOF -> ABORT pulses once, next word built from SOF nibble, no stale nibbles.
REQ-035 Assert RESET_N low after 5 nibbles -> all outputs reset immediately; next 8 nibbles form a clean word.
REQ-036 With TURBO_NIBBLE_PARITY_EN, I=4'b0001 with NIB_PAR=0 -> PAR_ERR=1 and stays high; without macro -> PAR_ERR=0.
REQ-037 NIBBLES=2, stream 4'hF,4'h0 continuously with WORD_READY=1 -> WORD=8'h0F every 2 cycles, no stalls.
